div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: div_start  in  1  EX stage holds a valid DIV/DIVU (es_valid & div op).
REQ-005 SHALL have port: div_signed  in  1  1=DIV (signed), 0=DIVU.
REQ-006 SHALL have port: div_src1  in  32  dividend (rs).
REQ-007 SHALL have port: div_src2  in  32  divisor (rt).
REQ-008 SHALL have port: es_flush  in  1  cancel the in-flight divide (exception/eret).
REQ-009 SHALL have port: div_stop  out  1  stall request to the hazard unit; holds EX while it is 1.
REQ-010 SHALL have port: div_done  out  1  one-cycle pulse; div_q and div_r are valid in this cycle.
REQ-011 SHALL have port: div_q  out  32  quotient, written to LO by EX/MEM.
REQ-012 SHALL have port: div_r  out  32  remainder, written to HI by EX/MEM.

Function
REQ-013 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-014 SHALL, in IDLE with div_start=1 and es_flush=0, latch operands, signedness and the 6-bit counter (=0), then go to BUSY; otherwise remain in IDLE.
REQ-015 SHALL perform one restoring radix-2 step per BUSY cycle on operand magnitudes (absolute values when div_signed=1).
REQ-016 SHALL stay in BUSY for exactly 32 cycles (counter 0..31), then go to DONE.
REQ-017 SHALL go from DONE to IDLE unconditionally after one cycle; div_start seen in DONE SHALL be ignored.
REQ-018 SHALL drive div_stop = (IDLE & div_start & ~es_flush) | (BUSY & ~es_flush), combinationally.
REQ-019 SHALL drive div_stop=0 and div_done=1 in DONE, so EX advances in that cycle.
REQ-020 SHALL give latency: start accepted in cycle 0; div_stop high in cycles 0..32 (33 cycles); div_done in cycle 33.
REQ-021 SHALL ignore changes on div_src1, div_src2 and div_signed after acceptance.
REQ-022 SHALL, when signed, give quotient sign = src1[31]^src2[31] and remainder sign = src1[31], applied by two's-complement negation in DONE.
REQ-023 SHALL, for a zero divisor (either signedness), return div_q=32'hFFFFFFFF and div_r=src1; timing SHALL be unchanged and no exception SHALL be raised.
REQ-024 SHALL, for signed 32'h80000000 / 32'hFFFFFFFF, return div_q=32'h80000000 and div_r=0.
REQ-025 SHALL, on es_flush=1 in any state, force div_stop=0, suppress div_done, and enter IDLE at the next edge.
REQ-026 SHALL hold div_q and div_r stable from DONE until the next accepted start.
REQ-027 SHALL accept a new start in the IDLE cycle that immediately follows DONE, allowing back-to-back divides.

Reset
REQ-028 SHALL, on reset=1 at a clock edge, enter IDLE, clear the counter, and set div_q=0, div_r=0, div_done=0; reset SHALL take priority over all inputs, including mid-BUSY.
REQ-029 SHALL drive div_stop=0 during any cycle in which reset=1.

Verification
REQ-030 SHALL cover: DIVU 100/7 -> div_stop high cycles 0..32, div_done in cycle 33 with q=14, r=2.
REQ-031 SHALL cover: DIV 0xFFFFFFF9/2 (-7/2) -> q=0xFFFFFFFD, r=0xFFFFFFFF.
REQ-032 SHALL cover: DIV 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0; DIVU 5/0 -> q=0xFFFFFFFF, r=5, both at cycle 33.
REQ-033 SHALL cover: es_flush in cycle 10 of BUSY -> div_stop=0 that cycle, IDLE in cycle 11, no div_done; a new start in cycle 12 completes normally in cycle 45.
REQ-034 SHALL cover: reset in cycle 20 of BUSY -> IDLE, q=r=0, div_done never asserted; operands changed mid-BUSY -> result uses the latched values.
REQ-035 SHALL cover: back-to-back DIVU 9/3 then 10/4 -> first done q=3, r=0; start in the following IDLE cycle; second done 34 cycles later with q=2, r=2.

Source files
------------

// File: rtl/div_unit.sv
// Multi-cycle restoring radix-2 divider for DIV/DIVU in the EX stage.
// It stalls the pipeline while busy and pulses div_done when quotient and remainder are ready.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] div_src1,
    input  logic [WIDTH-1:0] div_src2,
    input  logic             es_flush,
    output logic             div_stop,
    output logic             div_done,
    output logic [WIDTH-1:0] div_q,
    output logic [WIDTH-1:0] div_r
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic [5:0]       count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] dividend_raw;
    logic             neg_q;
    logic             neg_r;
    logic             zero_div;

    logic             src1_neg;
    logic             src2_neg;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] sub;
    logic             step_ok;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quot_next;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A flush wins over everything except reset; neither stall nor done may leak out under it.
    always_comb begin
        state_next = state;
        div_stop   = 1'b0;
        div_done   = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (div_start && !es_flush) begin
                    accept     = 1'b1;
                    div_stop   = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                div_stop = !es_flush;
                if (count == LAST_STEP) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                div_done   = !es_flush;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (es_flush) begin
            state_next = IDLE;
        end
        if (reset) begin
            accept   = 1'b0;
            div_stop = 1'b0;
            div_done = 1'b0;
        end
    end

    always_comb begin
        src1_neg = div_signed & div_src1[WIDTH-1];
        src2_neg = div_signed & div_src2[WIDTH-1];
        mag1     = src1_neg ? negate(div_src1) : div_src1;
        mag2     = src2_neg ? negate(div_src2) : div_src2;
    end

    // The dividend shifts out of quot's top bit while quotient bits shift into its bottom.
    always_comb begin
        shifted   = {rem, quot[WIDTH-1]};
        step_ok   = (shifted >= {1'b0, divisor});
        sub       = shifted[WIDTH-1:0] - divisor;
        rem_next  = step_ok ? sub : shifted[WIDTH-1:0];
        quot_next = {quot[WIDTH-2:0], step_ok};
        if (zero_div) begin
            q_final = '1;
            r_final = dividend_raw;
        end else begin
            q_final = neg_q ? negate(quot_next) : quot_next;
            r_final = neg_r ? negate(rem_next) : rem_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count        <= '0;
            rem          <= '0;
            quot         <= '0;
            divisor      <= '0;
            dividend_raw <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            zero_div     <= 1'b0;
            div_q        <= '0;
            div_r        <= '0;
        end else if (accept) begin
            count        <= '0;
            rem          <= '0;
            quot         <= mag1;
            divisor      <= mag2;
            dividend_raw <= div_src1;
            neg_q        <= src1_neg ^ src2_neg;
            neg_r        <= src1_neg;
            zero_div     <= (div_src2 == '0);
        end else if (state == BUSY && !es_flush) begin
            count <= count + 6'd1;
            rem   <= rem_next;
            quot  <= quot_next;
            if (count == LAST_STEP) begin
                div_q <= q_final;
                div_r <= r_final;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: table-driven vectors with a result scoreboard,
// plus hand-written flush, reset and hold sequences.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_src1;
    logic [31:0] div_src2;
    logic        es_flush;
    logic        div_stop;
    logic        div_done;
    logic [31:0] div_q;
    logic [31:0] div_r;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    vec_t vecs[$];
    exp_t scoreboard[$];

    div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .div_start (div_start),
        .div_signed(div_signed),
        .div_src1  (div_src1),
        .div_src2  (div_src2),
        .es_flush  (es_flush),
        .div_stop  (div_stop),
        .div_done  (div_done),
        .div_q     (div_q),
        .div_r     (div_r)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic signed [31:0] sa;
        logic signed [31:0] sbv;
        sa  = a;
        sbv = b;
        if (b == 32'h0) begin
            e.q = 32'hFFFFFFFF;
            e.r = a;
        end else if (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            e.q = 32'h80000000;
            e.r = 32'h0;
        end else if (sgn) begin
            e.q = sa / sbv;
            e.r = sa % sbv;
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Called at posedge+1 of cycle 0; returns at posedge+1 of cycle 34 (the IDLE after DONE).
    task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] q, input logic [31:0] r);
        exp_t e;
        int   bad_stop;
        int   bad_done;
        e.q = q;
        e.r = r;
        scoreboard.push_back(e);
        div_start  = 1'b1;
        div_signed = sgn;
        div_src1   = a;
        div_src2   = b;
        @(negedge clk);
        checkOutput("stop_accept", {31'b0, div_stop}, 32'd1);
        tick();
        div_start = 1'b0;
        bad_stop  = 0;
        bad_done  = 0;
        for (int c = 1; c <= 32; c++) begin
            div_src1   = $urandom;
            div_src2   = $urandom;
            div_signed = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (div_stop !== 1'b1) bad_stop++;
            if (div_done !== 1'b0) bad_done++;
            tick();
        end
        checkOutput("stop_busy_bad_cycles", 32'(bad_stop), 32'd0);
        checkOutput("done_early_cycles", 32'(bad_done), 32'd0);
        @(negedge clk);
        checkOutput("stop_in_done", {31'b0, div_stop}, 32'd0);
        checkOutput("done_pulse", {31'b0, div_done}, 32'd1);
        tick();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (div_done === 1'b1) begin
            if (scoreboard.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: actual=1 expected=0");
            end else begin
                e = scoreboard.pop_front();
                checkOutput("quotient", div_q, e.q);
                checkOutput("remainder", div_r, e.r);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        vec_t v;

        vecs.push_back('{1'b0, 32'd100,        32'd7,          32'd14,         32'd2});
        vecs.push_back('{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF});
        vecs.push_back('{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'h0});
        vecs.push_back('{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5});
        vecs.push_back('{1'b1, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF9});
        vecs.push_back('{1'b0, 32'd9,          32'd3,          32'd3,          32'd0});
        vecs.push_back('{1'b0, 32'd10,         32'd4,          32'd2,          32'd2});
        vecs.push_back('{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'h0});
        vecs.push_back('{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'h0,          32'h80000000});
        vecs.push_back('{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1});
        vecs.push_back('{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF});
        vecs.push_back('{1'b0, 32'd0,          32'd9,          32'd0,          32'd0});
        vecs.push_back('{1'b0, 32'h12345678,   32'd1000,       32'h0004A90B,   32'h00000380});
        vecs.push_back('{1'b1, 32'h80000000,   32'd1,          32'h80000000,   32'h0});
        vecs.push_back('{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0});
        for (int i = 0; i < 8; i++) begin
            v.sgn = (i % 2 == 1);
            v.a   = $urandom;
            v.b   = (i % 4 < 2) ? 32'($urandom_range(1, 1000)) : $urandom;
            e     = model(v.sgn, v.a, v.b);
            v.q   = e.q;
            v.r   = e.r;
            vecs.push_back(v);
        end

        reset      = 1'b1;
        div_start  = 1'b1;
        div_signed = 1'b0;
        div_src1   = 32'd100;
        div_src2   = 32'd7;
        es_flush   = 1'b0;
        @(negedge clk);
        checkOutput("stop_during_reset", {31'b0, div_stop}, 32'd0);
        tick();
        reset     = 1'b0;
        div_start = 1'b0;
        @(negedge clk);
        checkOutput("reset_q", div_q, 32'd0);
        checkOutput("reset_r", div_r, 32'd0);
        checkOutput("reset_done", {31'b0, div_done}, 32'd0);
        checkOutput("reset_stop_idle", {31'b0, div_stop}, 32'd0);
        tick();

        $display("[TB] running %0d table vectors back-to-back", vecs.size());
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);
        end

        v = vecs[vecs.size() - 1];
        div_src1   = 32'h0BADF00D;
        div_src2   = 32'h3;
        div_signed = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checkOutput("hold_q", div_q, v.q);
        checkOutput("hold_r", div_r, v.r);
        tick();

        $display("[TB] flush in cycle 10 of BUSY");
        div_start  = 1'b1;
        div_signed = 1'b0;
        div_src1   = 32'd77;
        div_src2   = 32'd5;
        tick();
        div_start = 1'b0;
        repeat (9) tick();
        es_flush = 1'b1;
        @(negedge clk);
        checkOutput("stop_under_flush", {31'b0, div_stop}, 32'd0);
        checkOutput("done_under_flush", {31'b0, div_done}, 32'd0);
        tick();
        es_flush = 1'b0;
        @(negedge clk);
        checkOutput("idle_after_flush", {31'b0, div_stop}, 32'd0);
        tick();
        applyStimulus(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1);

        $display("[TB] reset in cycle 20 of BUSY");
        div_start  = 1'b1;
        div_signed = 1'b0;
        div_src1   = 32'd50;
        div_src2   = 32'd5;
        tick();
        div_start = 1'b0;
        repeat (19) tick();
        reset = 1'b1;
        @(negedge clk);
        checkOutput("stop_reset_busy", {31'b0, div_stop}, 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midreset_q", div_q, 32'd0);
        checkOutput("midreset_r", div_r, 32'd0);
        checkOutput("midreset_stop", {31'b0, div_stop}, 32'd0);
        repeat (20) tick();
        applyStimulus(1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE);

        repeat (2) tick();
        checkOutput("scoreboard_empty", 32'(scoreboard.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
